// File: rtl/xfer_controller.sv
// Command-driven transfer controller: streams datapath register words out on reads and gathers words for a one-cycle commit on writes.
// Optional build macro COPRO_CMD_CHECK_EN adds err_o and drops commands with reserved bits set or a bad index.
module xfer_controller #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned NUM_REGS  = 16,
    parameter int unsigned MAX_WORDS = 8,
    parameter int unsigned ADDR_W    = 4,
    parameter logic [63:0] LEN_TABLE = 64'h1555_1144_1884_1444
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [WORD_W-1:0]           cmd_data_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [WORD_W-1:0]           rsp_data_o,
    output logic [ADDR_W-1:0]           rd_sel_o,
    input  logic [WORD_W*MAX_WORDS-1:0] rd_data_i,
    output logic [NUM_REGS-1:0]         wr_en_o,
    output logic [WORD_W*MAX_WORDS-1:0] wr_bus_o,
`ifdef COPRO_CMD_CHECK_EN
    output logic                        err_o,
`endif
    output logic                        busy_o
);

    localparam int unsigned CNT_W = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int unsigned BUS_W = WORD_W * MAX_WORDS;

    typedef enum logic [1:0] {IDLE, READ, WLOAD, COMMIT} state_e;

    state_e                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      last_q;
    logic [ADDR_W-1:0]     rd_sel_q;
    logic [NUM_REGS-1:0]   wr_en_q;
    logic [BUS_W-1:0]      wr_bus_q;
    logic                  cmd_ready_q;
    logic                  rsp_valid_q;
    logic                  busy_q;
`ifdef COPRO_CMD_CHECK_EN
    logic                  err_q;
`endif

    logic [ADDR_W-1:0]     cmd_idx_c;
    logic                  cmd_wr_c;
    logic                  cmd_drop_c;

    // Index of the last word for a register: table nibble with 0 -> 1 and clamp to MAX_WORDS.
    function automatic logic [CNT_W-1:0] last_idx(input logic [ADDR_W-1:0] idx);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (32'(idx) == i) n = 32'(LEN_TABLE[4*i +: 4]);
        end
        if (n == 0) n = 1;
        if (n > MAX_WORDS) n = MAX_WORDS;
        return CNT_W'(n - 1);
    endfunction

    assign cmd_idx_c = cmd_data_i[ADDR_W-1:0];
    assign cmd_wr_c  = cmd_data_i[WORD_W-1];
`ifdef COPRO_CMD_CHECK_EN
    assign cmd_drop_c = (32'(cmd_idx_c) >= NUM_REGS) || (|cmd_data_i[WORD_W-2:ADDR_W]);
`else
    assign cmd_drop_c = (32'(cmd_idx_c) >= NUM_REGS);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= '0;
            rd_sel_q    <= '0;
            wr_en_q     <= '0;
            wr_bus_q    <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef COPRO_CMD_CHECK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            wr_en_q <= '0;
`ifdef COPRO_CMD_CHECK_EN
            err_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
`ifdef COPRO_CMD_CHECK_EN
                        err_q <= cmd_drop_c;
`endif
                        if (!cmd_drop_c) begin
                            rd_sel_q <= cmd_idx_c;
                            last_q   <= last_idx(cmd_idx_c);
                            cnt_q    <= '0;
                            busy_q   <= 1'b1;
                            if (cmd_wr_c) begin
                                state_q  <= WLOAD;
                                wr_bus_q <= '0;
                            end else begin
                                state_q     <= READ;
                                cmd_ready_q <= 1'b0;
                                rsp_valid_q <= 1'b1;
                            end
                        end
                    end
                end
                READ: begin
                    if (rsp_ready_i) begin
                        if (cnt_q == last_q) begin
                            state_q     <= IDLE;
                            rsp_valid_q <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                WLOAD: begin
                    if (cmd_valid_i) begin
                        wr_bus_q[WORD_W*32'(cnt_q) +: WORD_W] <= cmd_data_i;
                        if (cnt_q == last_q) begin
                            state_q     <= COMMIT;
                            cmd_ready_q <= 1'b0;
                            wr_en_q     <= NUM_REGS'(1) << rd_sel_q;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Read data is a live mux of the combinational datapath bus, selected by the registered index/count.
    assign rsp_data_o  = rd_data_i[WORD_W*32'(cnt_q) +: WORD_W];
    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rd_sel_o    = rd_sel_q;
    assign wr_en_o     = wr_en_q;
    assign wr_bus_o    = wr_bus_q;
    assign busy_o      = busy_q;
`ifdef COPRO_CMD_CHECK_EN
    assign err_o       = err_q;
`endif

endmodule

// File: tb/tb_xfer_controller.sv
// Directed bench for xfer_controller: default instance plus a narrow 16-bit/4-register instance.
module tb_xfer_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic         cmd_valid, cmd_ready, rsp_valid, rsp_ready, busy;
    logic [31:0]  cmd_data, rsp_data;
    logic [3:0]   rd_sel;
    logic [255:0] rd_data, wr_bus;
    logic [15:0]  wr_en;
`ifdef COPRO_CMD_CHECK_EN
    logic         err;
`endif

    logic         cmd_valid2, cmd_ready2, rsp_valid2, rsp_ready2, busy2;
    logic [15:0]  cmd_data2, rsp_data2;
    logic [1:0]   rd_sel2;
    logic [63:0]  rd_data2, wr_bus2;
    logic [3:0]   wr_en2;
`ifdef COPRO_CMD_CHECK_EN
    logic         err2;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    xfer_controller dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_data_i(cmd_data),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
        .rd_sel_o(rd_sel), .rd_data_i(rd_data), .wr_en_o(wr_en), .wr_bus_o(wr_bus),
`ifdef COPRO_CMD_CHECK_EN
        .err_o(err),
`endif
        .busy_o(busy)
    );

    // Narrow instance: reg0 nibble 9 (clamped to 4), reg1=1, reg2=4, reg3 nibble 0 (treated as 1).
    xfer_controller #(
        .WORD_W(16), .NUM_REGS(4), .MAX_WORDS(4), .ADDR_W(2),
        .LEN_TABLE(64'h0000_0000_0000_0419)
    ) dut2 (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid2), .cmd_ready_o(cmd_ready2), .cmd_data_i(cmd_data2),
        .rsp_valid_o(rsp_valid2), .rsp_ready_i(rsp_ready2), .rsp_data_o(rsp_data2),
        .rd_sel_o(rd_sel2), .rd_data_i(rd_data2), .wr_en_o(wr_en2), .wr_bus_o(wr_bus2),
`ifdef COPRO_CMD_CHECK_EN
        .err_o(err2),
`endif
        .busy_o(busy2)
    );

    function automatic logic [31:0] rd_word(input logic [3:0] sel, input int w);
        return 32'hA500_0000 | (32'(sel) << 8) | 32'(w);
    endfunction

    function automatic logic [15:0] rd_word2(input logic [1:0] sel, input int w);
        return 16'hB000 | (16'(sel) << 4) | 16'(w);
    endfunction

    // Datapath models: each register presents a recognisable word pattern.
    always_comb begin
        rd_data = '0;
        for (int w = 0; w < 8; w++) rd_data[32*w +: 32] = rd_word(rd_sel, w);
    end
    always_comb begin
        rd_data2 = '0;
        for (int w = 0; w < 4; w++) rd_data2[16*w +: 16] = rd_word2(rd_sel2, w);
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [255:0] exp_bus;

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b0;
        cmd_valid2 = 1'b0; cmd_data2 = '0; rsp_ready2 = 1'b1;
        step(2);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_bus", wr_bus, 0);
        check("rst_rd_sel", rd_sel, 0);
        rst = 1'b0;
        check("post_rst_ready", cmd_ready, 1);
        step();

        // Read register 5 (len 8) with rsp_ready held high.
        cmd_valid = 1'b1; cmd_data = 32'h0000_0005; rsp_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        check("rd_rd_sel", rd_sel, 5);
        check("rd_cmd_ready", cmd_ready, 0);
        check("rd_busy", busy, 1);
        for (int w = 0; w < 8; w++) begin
            check($sformatf("rd_valid_%0d", w), rsp_valid, 1);
            check($sformatf("rd_data_%0d", w), rsp_data, rd_word(4'd5, w));
            step();
        end
        check("rd_done_valid", rsp_valid, 0);
        check("rd_done_ready", cmd_ready, 1);
        check("rd_done_busy", busy, 0);

        // Back-to-back write to register 12 (len 5).
        cmd_valid = 1'b1; cmd_data = 32'h8000_000C;
        step();
        check("wr_cmd_ready", cmd_ready, 1);
        check("wr_busy", busy, 1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("wr_load_en_%0d", i), wr_en, 0);
            cmd_data = 32'h11 * 32'(i + 1);
            step();
        end
        cmd_valid = 1'b0;
        exp_bus = '0;
        for (int i = 0; i < 5; i++) exp_bus[32*i +: 32] = 32'h11 * 32'(i + 1);
        check("wr_commit_en", wr_en, 16'h1000);
        check("wr_commit_bus", wr_bus, exp_bus);
        check("wr_commit_ready", cmd_ready, 0);
        step();
        check("wr_after_en", wr_en, 0);
        check("wr_after_ready", cmd_ready, 1);
        check("wr_after_busy", busy, 0);

        // Write to register 3 (len 1): bus is zeroed on accept.
        cmd_valid = 1'b1; cmd_data = 32'h8000_0003;
        step();
        check("wr3_bus_zeroed", wr_bus, 0);
        cmd_data = 32'h0000_00AB;
        step();
        cmd_valid = 1'b0;
        check("wr3_en", wr_en, 16'h0008);
        check("wr3_bus", wr_bus, 256'hAB);
        step();

        // Read register 3 with rsp_ready low for three cycles.
        cmd_valid = 1'b1; cmd_data = 32'h0000_0003; rsp_ready = 1'b0;
        step();
        cmd_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall_valid_%0d", k), rsp_valid, 1);
            check($sformatf("stall_data_%0d", k), rsp_data, rd_word(4'd3, 0));
            step();
        end
        check("stall_valid_end", rsp_valid, 1);
        rsp_ready = 1'b1;
        step();
        check("stall_done_valid", rsp_valid, 0);
        check("stall_done_ready", cmd_ready, 1);

        // Reset in the middle of a write to register 6.
        cmd_valid = 1'b1; cmd_data = 32'h8000_0006;
        step();
        cmd_data = 32'h0000_00D1;
        step();
        cmd_data = 32'h0000_00D2;
        step();
        rst = 1'b1; cmd_valid = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_wr_en", wr_en, 0);
        check("abort_wr_bus", wr_bus, 0);
        check("abort_rd_sel", rd_sel, 0);
        check("abort_rsp_valid", rsp_valid, 0);
        step(2);
        check("abort_hold_wr_en", wr_en, 0);
        rst = 1'b0;
        check("abort_ready", cmd_ready, 1);
        step();
        check("abort_after_en", wr_en, 0);
        check("abort_after_busy", busy, 0);

`ifdef COPRO_CMD_CHECK_EN
        // Reserved bit set: error pulse, command dropped.
        cmd_valid = 1'b1; cmd_data = 32'h0001_0002;
        step();
        cmd_valid = 1'b0;
        check("err_pulse", err, 1);
        check("err_no_rsp", rsp_valid, 0);
        check("err_ready", cmd_ready, 1);
        check("err_busy", busy, 0);
        step();
        check("err_cleared", err, 0);
        check("err_still_no_rsp", rsp_valid, 0);
`endif

        // Narrow instance: write register 2 (len 4).
        cmd_valid2 = 1'b1; cmd_data2 = 16'h8002;
        step();
        for (int i = 0; i < 4; i++) begin
            cmd_data2 = 16'h1111 * 16'(i + 1);
            step();
        end
        cmd_valid2 = 1'b0;
        check("n_wr_en", wr_en2, 4'b0100);
        check("n_wr_bus", wr_bus2, 64'h4444_3333_2222_1111);
        step();
        check("n_wr_en_after", wr_en2, 0);

        // Narrow instance: register 0 nibble 9 clamps to 4 words.
        cmd_valid2 = 1'b1; cmd_data2 = 16'h0000;
        step();
        cmd_valid2 = 1'b0;
        for (int w = 0; w < 4; w++) begin
            check($sformatf("n_clamp_valid_%0d", w), rsp_valid2, 1);
            check($sformatf("n_clamp_data_%0d", w), rsp_data2, rd_word2(2'd0, w));
            step();
        end
        check("n_clamp_done", rsp_valid2, 0);
        check("n_clamp_ready", cmd_ready2, 1);

        // Narrow instance: register 3 nibble 0 behaves as one word.
        cmd_valid2 = 1'b1; cmd_data2 = 16'h0003;
        step();
        cmd_valid2 = 1'b0;
        check("n_zero_valid", rsp_valid2, 1);
        check("n_zero_data", rsp_data2, rd_word2(2'd3, 0));
        step();
        check("n_zero_done", rsp_valid2, 0);
        check("n_zero_busy", busy2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
